// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port RAM arbiter for instruction fetch and data access.
//            Data wins by default, and a starvation counter forces an
//            instruction grant after STARVE_MAX data grants. A watchdog sets
//            a sticky err flag when an access waits too long for ram_ready.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err
);

  localparam int c_sw = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int c_tw = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);
  localparam logic [c_tw-1:0] c_timeout    = c_tw'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_sw-1:0]   starve_q, starve_d;
  logic [c_tw-1:0]   wait_q, wait_d;
  logic              err_q, err_d;
  logic              w_dreq;

  assign w_dreq = dREN | dWEN;
  // Read data goes straight through; only meaningful while the matching hit is high.
  assign iload  = ramload;
  assign dload  = ramload;
  assign err    = err_q;

  // State, starvation, watchdog and error registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  // Grant decision, RAM drive, hits and counter next-state.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        // Every access starts its watchdog from zero.
        wait_d = '0;
        if (w_dreq && !(iREN && (starve_q == c_starve_max))) begin
          state_d = DACC;
          // Below saturation here, because saturation with iREN forces IACC.
          if (iREN) starve_d = starve_q + 1'b1;
        end else if (iREN) begin
          state_d  = IACC;
          starve_d = '0;
        end
      end

      IACC: begin
        // A withdrawn request gets neither strobe nor hit.
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          ihit    = ram_ready;
        end
        if (!iREN || ram_ready) state_d = IDLE;
        if (!ram_ready && (wait_q != c_timeout)) wait_d = wait_q + 1'b1;
      end

      DACC: begin
        // If both requests are set, the write wins.
        if (w_dreq) begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          dhit     = ram_ready;
        end
        if (!w_dreq || ram_ready) state_d = IDLE;
        if (!ram_ready && (wait_q != c_timeout)) wait_d = wait_q + 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Fetch is not waiting, so it has no starvation history.
    if (!iREN) starve_d = '0;
  end

  // The watchdog reaching its limit latches err until reset.
  always_comb begin
    err_d = err_q | (wait_d == c_timeout);
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter. Directed scenarios are
//            followed by randomized traffic, checked against a behavioural
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner 0 = nobody, 1 = instruction, 2 = data
  int m_own = 0;
  int m_starve = 0;
  int m_wait = 0;
  bit m_err = 1'b0;
  bit obs_ihit, obs_dhit, obs_err;

  mem_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_starve = 0; m_wait = 0; m_err = 1'b0;
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic check_outputs();
    bit iact, dact, e_ren, e_wen, e_ihit, e_dhit;
    if (!nRST) model_reset();
    iact   = (m_own == 1) && iREN;
    dact   = (m_own == 2) && (dREN || dWEN);
    e_wen  = dact && dWEN;
    e_ren  = iact || (dact && dREN && !dWEN);
    e_ihit = iact && ram_ready;
    e_dhit = dact && ram_ready;
    chk("ihit",   32'(ihit),   32'(e_ihit));
    chk("dhit",   32'(dhit),   32'(e_dhit));
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("err",    32'(err),    32'(m_err));
    if (!nRST) begin
      chk("rst_ramaddr",  ramaddr,  32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
    end
    if (e_ren || e_wen) chk("ramaddr", ramaddr, iact ? iaddr : daddr);
    if (e_wen) chk("ramstore", ramstore, dstore);
    if (e_ihit) chk("iload", iload, ramload);
    if (e_dhit) chk("dload", dload, ramload);
    obs_ihit = ihit;
    obs_dhit = dhit;
    obs_err  = err;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_update();
    bit gd, gi, act;
    if (!nRST) begin
      model_reset();
      return;
    end
    if (m_own == 0) begin
      gd = (dREN || dWEN) && !(iREN && m_starve == STARVE);
      gi = !gd && iREN;
      if (gd && iREN) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      if (gi) m_starve = 0;
      m_own  = gd ? 2 : (gi ? 1 : 0);
      m_wait = 0;
    end else begin
      act = (m_own == 1) ? iREN : (dREN || dWEN);
      if (!ram_ready) begin
        if (m_wait < TMO) m_wait++;
        if (m_wait == TMO) m_err = 1'b1;
      end
      if (ram_ready || !act) m_own = 0;
    end
    if (!iREN) m_starve = 0;
  endtask

  task automatic step();
    @(negedge CLK);
    check_outputs();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int dg;
    bit seen_i;

    // Reset state
    #1 nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();

    // 1: reset in the middle of a data write
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234_5678;
    step();                 // grant
    step();                 // DACC, waiting
    nRST = 1'b0;
    #1;
    chk("t1_rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("t1_rst_dhit",   32'(dhit),   32'h0);
    chk("t1_rst_err",    32'(err),    32'h0);
    step();
    nRST = 1'b1;
    step();                 // fresh grant
    step();                 // DACC again, write strobe expected
    dWEN = 1'b0;
    step();

    // 2: instruction fetch with two waiting cycles
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'h2402_000A;
    step();
    step();
    step();
    ram_ready = 1'b1;
    step();
    chk("t2_ihit", 32'(obs_ihit), 32'h1);
    iREN = 1'b0; ram_ready = 1'b0;
    step();

    // 3: both requesters, data wins first
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    step();
    ram_ready = 1'b1;
    step();
    chk("t3_dhit", 32'(obs_dhit), 32'h1);
    dWEN = 1'b0; ram_ready = 1'b0;
    step();
    ram_ready = 1'b1;
    step();
    chk("t3_ihit", 32'(obs_ihit), 32'h1);
    iREN = 1'b0; ram_ready = 1'b0;
    step();

    // 4: starvation limit forces the fetch after STARVE data grants
    step();
    iREN = 1'b1; dWEN = 1'b1; ram_ready = 1'b1; ramload = 32'h0BAD_F00D;
    dg = 0; seen_i = 1'b0;
    for (int i = 0; i < 14 && !seen_i; i++) begin
      step();
      if (obs_dhit) dg++;
      if (obs_ihit) seen_i = 1'b1;
    end
    chk("t4_dgrants", 32'(dg), 32'(STARVE));
    chk("t4_ihit_seen", 32'(seen_i), 32'h1);
    step();                 // IDLE: counter cleared, data wins again
    step();
    chk("t4_data_again", 32'(obs_dhit), 32'h1);
    iREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    step();

    // 5: read+write together, then instruction withdrawal
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hCAFE_0001;
    step();
    ram_ready = 1'b1;
    step();
    dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    iREN = 1'b1; iaddr = 32'h44;
    step();                 // IDLE -> IACC
    step();                 // IACC waiting
    iREN = 1'b0;
    step();                 // withdrawn: no strobe, no hit
    chk("t5_no_ihit", 32'(obs_ihit), 32'h0);
    step();

    // 6: watchdog
    iREN = 1'b1; iaddr = 32'h48; ramload = 32'h1111_2222;
    step();                 // grant
    for (int i = 0; i < TMO; i++) step();
    chk("t6_err_not_yet", 32'(obs_err), 32'h0);
    step();
    chk("t6_err_set", 32'(obs_err), 32'h1);
    ram_ready = 1'b1;
    step();
    chk("t6_late_ihit", 32'(obs_ihit), 32'h1);
    chk("t6_err_sticky", 32'(obs_err), 32'h1);
    iREN = 1'b0; ram_ready = 1'b0;
    step();

    // Randomized traffic
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    for (int i = 0; i < 600; i++) begin
      iREN      = ($urandom_range(0, 3) != 0);
      dREN      = ($urandom_range(0, 2) == 0);
      dWEN      = ($urandom_range(0, 3) == 0);
      ram_ready = ($urandom_range(0, 2) == 0);
      iaddr     = $urandom;
      daddr     = $urandom;
      dstore    = $urandom;
      ramload   = $urandom;
      nRST      = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
